// File: rtl/alu_sequencer.sv
// alu_sequencer
// Issue/writeback stage that sits directly in front of a 16-bit combinational
// ALU. It latches an op code and a bus operand, drives the ALU inputs from
// registers, and holds them for a per-op settle interval. It then writes the
// ALU result into the accumulator, updates the zero flag and pulses done.
//
// Parameters:
//   WIDTH    - datapath width (operands, accumulator, ALU result)
//   MUL_WAIT - extra settle cycles for op 2 (multiply), 0..15
//   DIV_WAIT - extra settle cycles for ops 3 and 5 (divide, modulo), 0..15
//
// Ports:
//   clk, rst          - clock; asynchronous active-high reset
//   start, op, bus_in - request, op code and bus operand (sampled in IDLE)
//   alu_in1/alu_in2   - registered ALU operands (accumulator / bus operand)
//   alu_op            - registered ALU op select
//   alu_out           - combinational ALU result
//   ac, z             - accumulator and zero flag of the last writeback
//   busy, done        - not-idle indicator; one-cycle writeback pulse
//   div0              - divide-by-zero trap flag
//
// Optional feature macro: ALU_DIV0_TRAP_EN
//   When defined, a div/mod op with a zero accumulator skips the settle
//   interval and writes all ones with div0 set. When undefined, div0 stays 0
//   and a divide by zero takes the normal path.

module alu_sequencer #(
    parameter int WIDTH    = 16,
    parameter int MUL_WAIT = 2,
    parameter int DIV_WAIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] bus_in,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] ac,
    output logic             z,
    output logic             busy,
    output logic             done,
    output logic             div0
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        WB
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [3:0] wait_cnt;
    logic [3:0] settle;
    logic       is_div;
    logic       trap_hit;
    logic       trap_pending;

    // Settle interval and trap detection derive from the latched op, so they
    // are stable from ISSUE onward regardless of what the bus does.
    always_comb begin
        settle = 4'd0;
        is_div = 1'b0;
        case (alu_op)
            3'd2: settle = 4'(MUL_WAIT);
            3'd3,
            3'd5: begin
                settle = 4'(DIV_WAIT);
                is_div = 1'b1;
            end
            default: settle = 4'd0;
        endcase
`ifdef ALU_DIV0_TRAP_EN
        trap_hit = is_div && (alu_in1 == '0);
`else
        trap_hit = 1'b0;
`endif
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. WAIT leaves on the cycle the counter reaches 1 so that
    // exactly 'settle' cycles are spent there.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                if (trap_hit || (settle == 4'd0)) begin
                    next_state = WB;
                end else begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt <= 4'd1) begin
                    next_state = WB;
                end
            end
            WB: begin
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Datapath registers: operand capture, settle counter, writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_in1      <= '0;
            alu_in2      <= '0;
            alu_op       <= '0;
            ac           <= '0;
            z            <= 1'b0;
            done         <= 1'b0;
            div0         <= 1'b0;
            wait_cnt     <= '0;
            trap_pending <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        alu_op       <= op;
                        alu_in2      <= bus_in;
                        alu_in1      <= ac;
                        div0         <= 1'b0;
                        trap_pending <= 1'b0;
                    end
                end
                ISSUE: begin
                    wait_cnt     <= settle;
                    trap_pending <= trap_hit;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                end
                WB: begin
                    done <= 1'b1;
                    if (trap_pending) begin
                        ac   <= '1;
                        z    <= 1'b0;
                        div0 <= 1'b1;
                    end else begin
                        ac <= alu_out;
                        z  <= (alu_out == '0);
                    end
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer
// Table-driven bench for alu_sequencer with default parameters
// (MUL_WAIT=2, DIV_WAIT=4). A small behavioural ALU stands in for the real
// one. Its divide and modulo by zero return 16'h1234, so an untrapped divide
// by zero is visible in the accumulator.

module tb_alu_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [15:0] bus_in;
    logic [15:0] alu_in1;
    logic [15:0] alu_in2;
    logic [2:0]  alu_op;
    logic [15:0] alu_out;
    logic [15:0] ac;
    logic        z;
    logic        busy;
    logic        done;
    logic        div0;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [15:0] model_ac;

    alu_sequencer dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .bus_in  (bus_in),
        .alu_in1 (alu_in1),
        .alu_in2 (alu_in2),
        .alu_op  (alu_op),
        .alu_out (alu_out),
        .ac      (ac),
        .z       (z),
        .busy    (busy),
        .done    (done),
        .div0    (div0)
    );

    // Free-running clock, 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in combinational ALU.
    always_comb begin
        case (alu_op)
            3'd0: alu_out = alu_in1 + alu_in2;
            3'd1: alu_out = alu_in1 - alu_in2;
            3'd2: alu_out = 16'(alu_in1 * alu_in2);
            3'd3: alu_out = (alu_in1 == 16'd0) ? 16'h1234 : alu_in2 / alu_in1;
            3'd4: alu_out = alu_in2;
            3'd5: alu_out = (alu_in1 == 16'd0) ? 16'h1234 : alu_in2 % alu_in1;
            default: alu_out = alu_in1 + alu_in2;
        endcase
    end

    typedef struct {
        logic [2:0]  op;
        logic [15:0] bus;
        logic [15:0] exp_ac;
        logic        exp_z;
        int          exp_lat;
    } vec_t;

    vec_t vecs [14];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total_cnt++;
        if (actual === expected) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Issue one op (called in the cycle after an edge), wait for done, check.
    // glitch > 0 pulses an extra start in that cycle of the operation.
    task automatic applyStimulus(input logic [2:0] o, input logic [15:0] b,
                                 input logic [15:0] eac, input logic ez,
                                 input int elat, input logic ediv0,
                                 input int glitch);
        int   lat;
        logic stable;
        start  = 1'b1;
        op     = o;
        bus_in = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("issue_in1", alu_in1, model_ac);
        checkOutput("issue_in2", alu_in2, b);
        checkOutput("issue_op", alu_op, o);
        checkOutput("issue_busy", busy, 1'b1);
        checkOutput("div0_clear", div0, 1'b0);
        lat    = 0;
        stable = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            if (n == glitch) begin
                start  = 1'b1;
                op     = 3'd4;
                bus_in = 16'h0077;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (alu_in1 !== model_ac || alu_in2 !== b || alu_op !== o) begin
                stable = 1'b0;
            end
            if (done === 1'b1) begin
                lat = n;
                break;
            end
        end
        checkOutput("latency", lat, elat);
        checkOutput("ac", ac, eac);
        checkOutput("z", z, ez);
        checkOutput("div0", div0, ediv0);
        checkOutput("busy_in_done", busy, 1'b0);
        checkOutput("operands_stable", stable, 1'b1);
        model_ac = eac;
    endtask

    initial begin
        vecs[0]  = '{3'd4, 16'h0005, 16'h0005, 1'b0, 2};
        vecs[1]  = '{3'd0, 16'h0003, 16'h0008, 1'b0, 2};
        vecs[2]  = '{3'd1, 16'h0008, 16'h0000, 1'b1, 2};
        vecs[3]  = '{3'd1, 16'h0001, 16'hFFFF, 1'b0, 2};
        vecs[4]  = '{3'd4, 16'h0100, 16'h0100, 1'b0, 2};
        vecs[5]  = '{3'd2, 16'h0100, 16'h0000, 1'b1, 4};
        vecs[6]  = '{3'd4, 16'h0003, 16'h0003, 1'b0, 2};
        vecs[7]  = '{3'd3, 16'h000A, 16'h0003, 1'b0, 6};
        vecs[8]  = '{3'd4, 16'h0003, 16'h0003, 1'b0, 2};
        vecs[9]  = '{3'd5, 16'h000A, 16'h0001, 1'b0, 6};
        vecs[10] = '{3'd6, 16'h0002, 16'h0003, 1'b0, 2};
        vecs[11] = '{3'd7, 16'hFFFD, 16'h0000, 1'b1, 2};
        vecs[12] = '{3'd4, 16'h0007, 16'h0007, 1'b0, 2};
        vecs[13] = '{3'd2, 16'h0006, 16'h002A, 1'b0, 4};

        rst      = 1'b1;
        start    = 1'b0;
        op       = 3'd0;
        bus_in   = 16'h0000;
        model_ac = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ac", ac, 16'h0000);
        checkOutput("rst_z", z, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_div0", div0, 1'b0);
        checkOutput("rst_alu", {alu_in1, alu_in2[12:0], alu_op}, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back table run: each op is issued in the previous done cycle.
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].op, vecs[i].bus, vecs[i].exp_ac, vecs[i].exp_z,
                          vecs[i].exp_lat, 1'b0, 0);
        end
        @(posedge clk);
        #1;
        checkOutput("done_one_cycle", done, 1'b0);

        // Start pulsed during WAIT must be ignored; exactly one done.
        applyStimulus(3'd4, 16'h0003, 16'h0003, 1'b0, 2, 1'b0, 0);
        applyStimulus(3'd3, 16'h000A, 16'h0003, 1'b0, 6, 1'b0, 2);
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1;
            checkOutput("no_extra_done", done, 1'b0);
        end
        checkOutput("idle_after_glitch", busy, 1'b0);

        // Asynchronous reset in WAIT discards the operation.
        applyStimulus(3'd4, 16'h0005, 16'h0005, 1'b0, 2, 1'b0, 0);
        start  = 1'b1;
        op     = 3'd2;
        bus_in = 16'h0003;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        checkOutput("abort_busy_before", busy, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("abort_ac", ac, 16'h0000);
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_alu", {alu_in1, alu_in2[12:0], alu_op}, 32'h0);
        #1;
        rst = 1'b0;
        model_ac = 16'h0000;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1;
            checkOutput("abort_no_done", done, 1'b0);
        end
        checkOutput("abort_ac_hold", ac, 16'h0000);

        // Divide by zero with ac = 0.
`ifdef ALU_DIV0_TRAP_EN
        applyStimulus(3'd3, 16'h0010, 16'hFFFF, 1'b0, 2, 1'b1, 0);
`else
        applyStimulus(3'd3, 16'h0010, 16'h1234, 1'b0, 6, 1'b0, 0);
`endif
        applyStimulus(3'd4, 16'h0007, 16'h0007, 1'b0, 2, 1'b0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle issue/writeback stage placed directly upstream of the 16-bit combinational ALU in each core. It latches an operation code and a bus operand, drives the ALU operand and op inputs, and holds them stable for a per-operation settle interval so the slow multiply and divide paths meet timing. It then captures the ALU result into the core's accumulator, updates the zero flag and pulses `done`.

## Interface
- `WIDTH`, 16: datapath width of operands, accumulator and ALU result.
- `MUL_WAIT`, 2: extra settle cycles for op 2 (multiply); legal range 0-15.
- `DIV_WAIT`, 4: extra settle cycles for ops 3 and 5 (divide, modulo); legal range 0-15.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  3  operation: 0 add, 1 sub, 2 mul, 3 div (bus/ac), 4 load bus, 5 mod (bus%ac), 6-7 reserved.
- `bus_in`  in  WIDTH  bus operand, sampled with `start`.
- `alu_in1`  out  WIDTH  to ALU in1; carries the accumulator value.
- `alu_in2`  out  WIDTH  to ALU in2; carries the latched bus operand.
- `alu_op`  out  3  to ALU op select.
- `alu_out`  in  WIDTH  from ALU result.
- `ac`  out  WIDTH  accumulator.
- `z`  out  1  set when the last written-back result is zero.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse after writeback.
- `div0`  out  1  divide-by-zero trap flag.

## Operation
- States: IDLE, ISSUE, WAIT, WB.
- IDLE, `start`=1: latch `op` into `alu_op` and `bus_in` into `alu_in2`; load `alu_in1` from `ac`; go to ISSUE. `start`=0: remain in IDLE.
- ISSUE: load the wait counter with k. k is `MUL_WAIT` for op 2, `DIV_WAIT` for ops 3 and 5, and 0 otherwise. Go to WAIT if k>0, else go to WB.
- WAIT: decrement the counter. Go to WB after exactly k cycles in WAIT.
- WB: `ac` <= `alu_out`; `z` <= (`alu_out` == 0); `done` <= 1; go to IDLE.
- `alu_in1`, `alu_in2` and `alu_op` are registered. They stay constant from ISSUE through WB and hold their last values in IDLE.
- Ops 6 and 7 pass through unchanged, so the ALU default (add) applies, with k=0.
- Results are truncated to WIDTH bits. No carry or overflow is reported.
- `start` while `busy` is ignored; there is no queueing.

## Timing
- Reset values: `ac`=0, `z`=0, `busy`=0, `done`=0, `div0`=0, `alu_in1`=0, `alu_in2`=0, `alu_op`=0, state IDLE.
- Latency: with `start` sampled at edge E0, `done` is high during the cycle after edge E(2+k), and `ac` and `z` are valid in that same cycle.
- Resulting latencies: add, sub, load, reserved = 2 cycles; mul = 2+`MUL_WAIT`; div and mod = 2+`DIV_WAIT`.
- `done` lasts exactly one cycle. `busy` is already 0 in the `done` cycle, so a `start` in that cycle is accepted: back-to-back issue with no gap.
- Reset mid-operation: all registers return to reset values immediately (asynchronous). No `done` is produced and the partial result is discarded.

## Configuration
- `ALU_DIV0_TRAP_EN` defined:
  - In ISSUE, if op is 3 or 5 and `alu_in1`==0, skip WAIT and go straight to WB.
  - WB then writes `ac`=all ones, `z`=0 and `div0`=1, and ignores `alu_out`.
  - `div0` stays set until the next accepted `start` clears it.
  - Latency for a trapped op is 2 cycles.
- `ALU_DIV0_TRAP_EN` undefined:
  - `div0` is tied to 0.
  - A divide by zero follows the normal div/mod path and writes whatever `alu_out` presents.

## Test plan
- Reset: assert `rst` mid-cycle -> all outputs 0 at once, with no clock edge required.
- Load then add: op4 with bus 0x0005 -> `done` 2 cycles later, `ac`=0x0005, `z`=0. Then op0 with bus 0x0003 -> `ac`=0x0008.
- Multiply truncation: `ac`=0x0100, op2 with bus 0x0100 -> `done` after 4 cycles (default `MUL_WAIT`), `ac`=0x0000, `z`=1. `alu_in1`, `alu_in2` and `alu_op` must be stable throughout.
- Divide and modulo: `ac`=0x0003, op3 with bus 0x000A -> `ac`=0x0003 after 6 cycles. Reload `ac`=3, op5 with bus 0x000A -> `ac`=0x0001.
- Busy and abort:
  - Pulse `start` during WAIT -> ignored, with exactly one `done`.
  - Assert `rst` in WAIT -> IDLE, no `done`, `ac`=0.
  - `start` in the `done` cycle -> accepted.
- Divide by zero: `ac`=0, op3 with bus 0x0010.
  - With the macro: `ac`=0xFFFF and `div0`=1 after 2 cycles; the next `start` clears `div0`.
  - Without the macro: `div0`=0 and latency is 6.
